// File: rtl/functional_sweep_checker_if.sv
// Bundle between the sweep checker and the functional unit environment.
// The master side is the checker: it drives operands and status and receives start and F.
interface functional_sweep_checker_if #(
    parameter int ERR_W = 7
);
    logic             start;
    logic [1:0]       f_in;
    logic [1:0]       a_out;
    logic [1:0]       b_out;
    logic [1:0]       i_out;
    logic             busy;
    logic             done;
    logic             fail;
    logic [ERR_W-1:0] err_count;
    logic [5:0]       first_fail;

    modport master (
        input  start, f_in,
        output a_out, b_out, i_out, busy, done, fail, err_count, first_fail
    );

    modport slave (
        output start, f_in,
        input  a_out, b_out, i_out, busy, done, fail, err_count, first_fail
    );
endinterface

// File: rtl/functional_sweep_checker.sv
// Stimulus/response checker for the 2-bit functional unit (A, B, I -> F).
// Walks all 64 {A,B,I} vectors, lets F settle, compares against a golden model
// and records the mismatch count and the first failing vector.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start, outputs held
//   LOAD   | drive operands of the current vector, arm settle counter
//   SETTLE | count down while the unit's F settles
//   SAMPLE | compare F with golden model, update error record
//   NEXT   | advance vector or finish the sweep
//   DONE   | sweep complete, results held until next start
module functional_sweep_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 7
) (
    input logic                       clk,
    input logic                       rst,
    functional_sweep_checker_if.master bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state;
    logic [5:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       a_q;
    logic [1:0]       b_q;
    logic [1:0]       i_q;
    logic             busy_q;
    logic             done_q;
    logic             fail_q;
    logic [ERR_W-1:0] err_q;
    logic [5:0]       first_q;

    function automatic logic [1:0] f_golden(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] i);
        logic [1:0] r;
        case (i)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Sweep sequencer with all outputs registered; f_in only matters in SAMPLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            fail_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= LOAD;
                        vec_q   <= '0;
                        err_q   <= '0;
                        first_q <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    {a_q, b_q, i_q} <= vec_q;
                    cnt_q           <= CNT_W'(SETTLE_CYCLES - 1);
                    state           <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (bus.f_in != f_golden(a_q, b_q, i_q)) begin
                        fail_q <= 1'b1;
                        if (err_q != '1) begin
                            err_q <= err_q + 1'b1;
                        end
                        if (err_q == '0) begin
                            first_q <= vec_q;
                        end
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    if (vec_q == 6'd63) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        vec_q <= vec_q + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.i_out      = i_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = first_q;
endmodule

// File: tb/tb_functional_sweep_checker.sv
// Directed bench: correct, stuck-at-zero and single-vector-corrupted unit models,
// start while busy, reset mid-sweep, and a 1-settle-cycle instance with a delayed unit.
module tb_functional_sweep_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    functional_sweep_checker_if #(.ERR_W(7)) ifc1 ();
    functional_sweep_checker_if #(.ERR_W(7)) ifc2 ();

    functional_sweep_checker #(.SETTLE_CYCLES(4), .ERR_W(7)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.master)
    );

    functional_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(7)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifc2.master)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] unit_ref(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] i);
        if (i == 2'd0) return a & b;
        if (i == 2'd1) return a | b;
        if (i == 2'd2) return a ^ b;
        return 2'((int'(a) + int'(b)) % 4);
    endfunction

    // Unit model for dut1: 0 correct, 1 stuck at zero, 2 wrong only at A=3,B=2,I=3.
    always_comb begin
        ifc1.f_in = unit_ref(ifc1.a_out, ifc1.b_out, ifc1.i_out);
        if (mode == 1) ifc1.f_in = 2'b00;
        if (mode == 2 && ifc1.a_out == 2'd3 && ifc1.b_out == 2'd2 && ifc1.i_out == 2'd3)
            ifc1.f_in = 2'b00;
    end

    // Unit model for dut2: correct result, one clock late.
    always @(posedge clk) ifc2.f_in <= unit_ref(ifc2.a_out, ifc2.b_out, ifc2.i_out);

    task automatic check_eq(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one dut1 sweep from a start pulse until done (bounded); optionally pokes start at vec 10.
    task automatic sweep1(input bit poke, output int cycles, output int fails,
                          output bit order_ok, output bit busy_at1, output bit done_at1);
        cycles   = 0;
        fails    = 0;
        order_ok = 1'b1;
        busy_at1 = 1'b0;
        done_at1 = 1'b1;
        @(negedge clk);
        ifc1.start = 1'b1;
        while (cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            ifc1.start = 1'b0;
            if (cycles == 1) begin
                busy_at1 = ifc1.busy;
                done_at1 = ifc1.done;
            end
            if (ifc1.fail) fails++;
            if (cycles >= 2 && (cycles - 2) % 7 == 0 && (cycles - 2) / 7 < 64) begin
                if (int'({ifc1.a_out, ifc1.b_out, ifc1.i_out}) != (cycles - 2) / 7)
                    order_ok = 1'b0;
                if (poke && (cycles - 2) / 7 == 10) ifc1.start = 1'b1;
            end
            if (ifc1.done) break;
        end
    endtask

    int cycles;
    int fails;
    bit order_ok;
    bit busy_at1;
    bit done_at1;

    initial begin
        ifc1.start = 1'b0;
        ifc2.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ops", int'({ifc1.a_out, ifc1.b_out, ifc1.i_out}), 0);
        check_eq("rst_flags", int'({ifc1.busy, ifc1.done, ifc1.fail}), 0);
        check_eq("rst_err", int'(ifc1.err_count), 0);
        check_eq("rst_first", int'(ifc1.first_fail), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mode = 0;
        sweep1(1'b0, cycles, fails, order_ok, busy_at1, done_at1);
        check_eq("good_cycles", cycles, 449);
        check_eq("good_fails", fails, 0);
        check_eq("good_err", int'(ifc1.err_count), 0);
        check_eq("good_order", int'(order_ok), 1);
        check_eq("good_busy_at_load", int'(busy_at1), 1);
        check_eq("good_done_at_load", int'(done_at1), 0);
        check_eq("good_busy_done", int'(ifc1.busy), 0);
        check_eq("good_ops_hold", int'({ifc1.a_out, ifc1.b_out, ifc1.i_out}), 63);
        repeat (3) @(negedge clk);
        check_eq("good_done_hold", int'(ifc1.done), 1);

        mode = 1;
        sweep1(1'b0, cycles, fails, order_ok, busy_at1, done_at1);
        check_eq("stuck_cycles", cycles, 449);
        check_eq("stuck_err", int'(ifc1.err_count), 46);
        check_eq("stuck_fails", fails, 46);
        check_eq("stuck_first", int'(ifc1.first_fail), 6'b000101);
        check_eq("restart_done_clear", int'(done_at1), 0);

        mode = 2;
        sweep1(1'b0, cycles, fails, order_ok, busy_at1, done_at1);
        check_eq("corrupt_err", int'(ifc1.err_count), 1);
        check_eq("corrupt_first", int'(ifc1.first_fail), 6'b111011);
        check_eq("corrupt_fails", fails, 1);

        mode = 0;
        sweep1(1'b1, cycles, fails, order_ok, busy_at1, done_at1);
        check_eq("poke_cycles", cycles, 449);
        check_eq("poke_order", int'(order_ok), 1);
        check_eq("poke_err", int'(ifc1.err_count), 0);

        // Reset in the second SETTLE cycle of vec 20 with errors already recorded.
        mode = 1;
        @(negedge clk);
        ifc1.start = 1'b1;
        cycles = 0;
        while (cycles < 2 + 7 * 20 + 1) begin
            @(posedge clk);
            cycles++;
            #1;
            ifc1.start = 1'b0;
        end
        check_eq("pre_rst_vec", int'({ifc1.a_out, ifc1.b_out, ifc1.i_out}), 20);
        check_eq("pre_rst_err_nz", int'(ifc1.err_count != 0), 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ops", int'({ifc1.a_out, ifc1.b_out, ifc1.i_out}), 0);
        check_eq("mid_rst_flags", int'({ifc1.busy, ifc1.done, ifc1.fail}), 0);
        check_eq("mid_rst_err", int'(ifc1.err_count), 0);
        check_eq("mid_rst_first", int'(ifc1.first_fail), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", int'({ifc1.busy, ifc1.done}), 0);
        mode = 0;
        sweep1(1'b0, cycles, fails, order_ok, busy_at1, done_at1);
        check_eq("post_rst_cycles", cycles, 449);
        check_eq("post_rst_err", int'(ifc1.err_count), 0);

        // One settle cycle, unit with one cycle of F latency.
        @(negedge clk);
        ifc2.start = 1'b1;
        cycles = 0;
        fails  = 0;
        while (cycles < 1000) begin
            @(posedge clk);
            cycles++;
            #1;
            ifc2.start = 1'b0;
            if (ifc2.fail) fails++;
            if (ifc2.done) break;
        end
        check_eq("fast_cycles", cycles, 257);
        check_eq("fast_err", int'(ifc2.err_count), 0);
        check_eq("fast_fails", fails, 0);
        check_eq("fast_ops_hold", int'({ifc2.a_out, ifc2.b_out, ifc2.i_out}), 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
